// File: rtl/up_data_rx_framer.sv
// Splits the UART RX byte stream into idle-gap-delimited frames, stores them in a
// 4096-byte ring on RAM port A and posts one (start, length) descriptor per stored frame.
module up_data_rx_framer #(
  parameter int IDLE_CYCLES = 1000,
  parameter int MAX_FRAME   = 2048
) (
  input  logic        sysclk,
  input  logic        nRST,
  input  logic        rx_vld,
  input  logic [7:0]  rx_data,
  input  logic        rx_err,
  output logic        ram_wren,
  output logic [11:0] ram_addr,
  output logic [7:0]  ram_data,
  input  logic [11:0] rd_ptr,
  output logic        frm_vld,
  input  logic        frm_rdy,
  output logic [11:0] frm_addr,
  output logic [11:0] frm_len,
  output logic [15:0] drop_cnt,
  output logic [1:0]  dbg_state
);

  localparam int GW = $clog2(IDLE_CYCLES);
  localparam logic [GW-1:0] GAP_LAST = GW'(IDLE_CYCLES - 1);
  localparam logic [11:0]   MAX_LEN  = 12'(MAX_FRAME);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RECV = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [11:0]     wr_ptr, commit_ptr, byte_cnt;
  logic [GW-1:0]   gap_cnt;

  logic space_ok, storable, gap_done, desc_free;
  logic do_write, cnt_first, rewind, gap_clr, gap_inc, do_post, drop_inc;

  // One slot always stays empty so wr_ptr never catches up with rd_ptr.
  assign space_ok  = (wr_ptr + 12'd1) != rd_ptr;
  assign storable  = !rx_err && space_ok;
  assign gap_done  = (gap_cnt == GAP_LAST);
  // Descriptor handshake: frm_vld/frm_addr/frm_len hold until an edge with frm_rdy=1
  // consumes them; a new descriptor may load on that same edge.
  assign desc_free = !frm_vld || frm_rdy;
  assign dbg_state = state;

  always_comb begin
    state_nxt = state;
    do_write  = 1'b0;
    cnt_first = 1'b0;
    rewind    = 1'b0;
    gap_clr   = 1'b0;
    gap_inc   = 1'b0;
    do_post   = 1'b0;
    drop_inc  = 1'b0;
    case (state)
      S_IDLE: begin
        if (rx_vld) begin
          gap_clr = 1'b1;
          if (storable) begin
            do_write  = 1'b1;
            cnt_first = 1'b1;
            state_nxt = S_RECV;
          end else begin
            state_nxt = S_DROP;
          end
        end
      end
      S_RECV: begin
        if (rx_vld) begin
          gap_clr = 1'b1;
          if (storable && (byte_cnt < MAX_LEN)) begin
            do_write = 1'b1;
          end else begin
            rewind    = 1'b1;
            state_nxt = S_DROP;
          end
        end else if (gap_done) begin
          gap_clr   = 1'b1;
          state_nxt = S_IDLE;
          if (desc_free) begin
            do_post = 1'b1;
          end else begin
            rewind   = 1'b1;
            drop_inc = 1'b1;
          end
        end else begin
          gap_inc = 1'b1;
        end
      end
      S_DROP: begin
        if (rx_vld) begin
          gap_clr = 1'b1;
        end else if (gap_done) begin
          gap_clr   = 1'b1;
          drop_inc  = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          gap_inc = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge sysclk or negedge nRST) begin
    if (!nRST) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge sysclk or negedge nRST) begin
    if (!nRST) begin
      wr_ptr     <= '0;
      commit_ptr <= '0;
      byte_cnt   <= '0;
      gap_cnt    <= '0;
      drop_cnt   <= '0;
    end else begin
      if (do_write) begin
        wr_ptr <= wr_ptr + 12'd1;
      end else if (rewind) begin
        wr_ptr <= commit_ptr;
      end
      if (cnt_first) begin
        byte_cnt <= 12'd1;
      end else if (do_write) begin
        byte_cnt <= byte_cnt + 12'd1;
      end
      if (gap_clr) begin
        gap_cnt <= '0;
      end else if (gap_inc) begin
        gap_cnt <= gap_cnt + 1'b1;
      end
      if (do_post) begin
        commit_ptr <= wr_ptr;
      end
      if (drop_inc && (drop_cnt != 16'hFFFF)) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge sysclk or negedge nRST) begin
    if (!nRST) begin
      ram_wren <= 1'b0;
      ram_addr <= '0;
      ram_data <= '0;
    end else begin
      ram_wren <= do_write;
      if (do_write) begin
        ram_addr <= wr_ptr;
        ram_data <= rx_data;
      end
    end
  end

  always_ff @(posedge sysclk or negedge nRST) begin
    if (!nRST) begin
      frm_vld  <= 1'b0;
      frm_addr <= '0;
      frm_len  <= '0;
    end else if (do_post) begin
      frm_vld  <= 1'b1;
      frm_addr <= commit_ptr;
      frm_len  <= byte_cnt;
    end else if (frm_rdy) begin
      frm_vld  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_up_data_rx_framer.sv
// Bench for up_data_rx_framer: directed frame table, hand-written corner sequences
// and random frames checked against a frame-level model of the ring and drop counter.
module tb_up_data_rx_framer;

  localparam int IDLE = 16;
  localparam int MAXF = 2048;

  logic        sysclk = 1'b0;
  logic        nRST = 1'b0;
  logic        rx_vld = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_err = 1'b0;
  logic [11:0] rd_ptr = 12'd0;
  logic        frm_rdy = 1'b0;
  logic        ram_wren, frm_vld;
  logic [11:0] ram_addr, frm_addr, frm_len;
  logic [7:0]  ram_data;
  logic [15:0] drop_cnt;
  logic [1:0]  dbg_state;

  up_data_rx_framer #(.IDLE_CYCLES(IDLE), .MAX_FRAME(MAXF)) dut (
    .sysclk(sysclk), .nRST(nRST), .rx_vld(rx_vld), .rx_data(rx_data), .rx_err(rx_err),
    .ram_wren(ram_wren), .ram_addr(ram_addr), .ram_data(ram_data), .rd_ptr(rd_ptr),
    .frm_vld(frm_vld), .frm_rdy(frm_rdy), .frm_addr(frm_addr), .frm_len(frm_len),
    .drop_cnt(drop_cnt), .dbg_state(dbg_state)
  );

  always #5 sysclk = ~sysclk;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mem [4096];
  logic [19:0] wr_log[$];
  logic [23:0] desc_log[$];
  logic [23:0] exp_q[$];
  logic        auto_release = 1'b0;
  logic        rel_pend = 1'b0;
  logic [11:0] rel_val = 12'd0;
  logic        p_ok = 1'b0, p_vld = 1'b0, p_rdy = 1'b0;
  logic [11:0] p_addr = 12'd0, p_len = 12'd0;

  typedef struct {
    int          n;
    int          err_pos;
    logic        exp_vld;
    logic [11:0] exp_addr;
    logic [11:0] exp_len;
    logic [15:0] exp_drop;
  } vec_t;
  vec_t vecs[6];

  int          first_k, len, errp, r, g, bad;
  logic [23:0] cap, got, want;
  logic [11:0] m_commit, a;
  logic [15:0] m_drop;
  logic [7:0]  d;
  logic [7:0]  fb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    rx_vld = 1'b0;
    rx_err = 1'b0;
    rd_ptr = 12'd0;
    rel_pend = 1'b0;
    repeat (2) @(negedge sysclk);
    nRST = 1'b1;
    wr_log.delete();
    desc_log.delete();
    exp_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] dat, input logic err);
    rx_vld = 1'b1;
    rx_data = dat;
    rx_err = err;
    @(negedge sysclk);
    rx_vld = 1'b0;
    rx_err = 1'b0;
  endtask

  task automatic send_frame(input int n, input logic [7:0] seed, input int err_pos);
    for (int i = 0; i < n; i++) send_byte(seed + 8'(i), (i + 1) == err_pos);
  endtask

  task automatic idle(input int k);
    repeat (k) @(negedge sysclk);
  endtask

  task automatic expect_desc(input string name, input logic [11:0] ea, input logic [11:0] el);
    logic [23:0] q;
    chk({name, "_cnt"}, desc_log.size(), 1);
    if (desc_log.size() > 0) begin
      q = desc_log.pop_front();
      chk({name, "_addr"}, q[23:12], ea);
      chk({name, "_len"}, q[11:0], el);
    end
    desc_log.delete();
  endtask

  // Observes the RAM port and the descriptor channel; acts as the consumer releasing rd_ptr.
  always begin
    @(negedge sysclk);
    #1;
    if (rel_pend && auto_release) rd_ptr = rel_val;
    rel_pend = 1'b0;
    if (nRST) begin
      if (ram_wren) begin
        mem[ram_addr] = ram_data;
        wr_log.push_back({ram_addr, ram_data});
      end
      if (frm_vld && frm_rdy) begin
        desc_log.push_back({frm_addr, frm_len});
        rel_pend = 1'b1;
        rel_val = frm_addr + frm_len;
      end
      if (p_ok && p_vld && !p_rdy) begin
        chk("hold_vld", frm_vld, 1);
        chk("hold_desc", {frm_addr, frm_len}, {p_addr, p_len});
      end
    end
    p_ok = nRST;
    p_vld = frm_vld;
    p_rdy = frm_rdy;
    p_addr = frm_addr;
    p_len = frm_len;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{10, 5, 1'b0, 12'd0, 12'd0, 16'd1};
    vecs[1] = '{2,  0, 1'b1, 12'd0, 12'd2, 16'd1};
    vecs[2] = '{1,  1, 1'b0, 12'd0, 12'd0, 16'd2};
    vecs[3] = '{5,  0, 1'b1, 12'd2, 12'd5, 16'd2};
    vecs[4] = '{3,  3, 1'b0, 12'd0, 12'd0, 16'd3};
    vecs[5] = '{4,  0, 1'b1, 12'd7, 12'd4, 16'd3};

    do_reset();
    chk("rst_wren", ram_wren, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_data", ram_data, 0);
    chk("rst_frm_vld", frm_vld, 0);
    chk("rst_frm_addr", frm_addr, 0);
    chk("rst_frm_len", frm_len, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_state", dbg_state, 0);

    // Basic frame: write latency, back-to-back bytes, close latency.
    frm_rdy = 1'b1;
    auto_release = 1'b1;
    send_byte(8'h11, 1'b0);
    chk("t1_wr0", {ram_wren, ram_addr, ram_data}, {1'b1, 12'd0, 8'h11});
    send_byte(8'h22, 1'b0);
    chk("t1_wr1", {ram_wren, ram_addr, ram_data}, {1'b1, 12'd1, 8'h22});
    send_byte(8'h33, 1'b0);
    chk("t1_wr2", {ram_wren, ram_addr, ram_data}, {1'b1, 12'd2, 8'h33});
    first_k = 0;
    cap = '0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge sysclk);
      if (frm_vld && first_k == 0) begin
        first_k = k;
        cap = {frm_addr, frm_len};
      end
    end
    chk("t1_close_lat", first_k, IDLE);
    chk("t1_desc", cap, {12'd0, 12'd3});
    desc_log.delete();

    // Table of frames with and without rx_err.
    do_reset();
    frm_rdy = 1'b1;
    auto_release = 1'b1;
    for (int v = 0; v < 6; v++) begin
      send_frame(vecs[v].n, 8'(v * 16), vecs[v].err_pos);
      idle(IDLE + 4);
      if (vecs[v].exp_vld) expect_desc($sformatf("tbl%0d", v), vecs[v].exp_addr, vecs[v].exp_len);
      else chk($sformatf("tbl%0d_nodesc", v), desc_log.size(), 0);
      chk($sformatf("tbl%0d_drop", v), drop_cnt, vecs[v].exp_drop);
    end

    // Ring wrap: two 2047-byte frames bring commit to 4094.
    do_reset();
    frm_rdy = 1'b1;
    auto_release = 1'b1;
    send_frame(2047, 8'h00, 0);
    idle(IDLE + 4);
    expect_desc("t3_f0", 12'd0, 12'd2047);
    send_frame(2047, 8'h40, 0);
    idle(IDLE + 4);
    expect_desc("t3_f1", 12'd2047, 12'd2047);
    for (int i = 0; i < 4; i++) begin
      send_byte(8'hC0 + 8'(i), 1'b0);
      chk($sformatf("t3_wrap_wr%0d", i), {ram_wren, ram_addr}, {1'b1, 12'(4094 + i)});
    end
    idle(IDLE + 4);
    expect_desc("t3_wrap", 12'd4094, 12'd4);

    // Space limit: rd_ptr pinned at 0.
    do_reset();
    frm_rdy = 1'b1;
    auto_release = 1'b0;
    send_frame(2048, 8'h01, 0);
    idle(IDLE + 4);
    expect_desc("t4_f0", 12'd0, 12'd2048);
    wr_log.delete();
    send_frame(2048, 8'h02, 0);
    idle(IDLE + 4);
    chk("t4_f1_nodesc", desc_log.size(), 0);
    chk("t4_drop", drop_cnt, 1);
    chk("t4_f1_writes", wr_log.size(), 2047);
    if (wr_log.size() > 0) chk("t4_f1_last_addr", wr_log[$][19:8], 12'd4094);
    send_byte(8'h5E, 1'b0);
    chk("t4_next_addr", {ram_wren, ram_addr}, {1'b1, 12'd2048});
    send_byte(8'h5F, 1'b0);
    idle(IDLE + 4);
    expect_desc("t4_next", 12'd2048, 12'd2);

    // Length limit: one byte over MAX_FRAME drops the frame.
    do_reset();
    frm_rdy = 1'b1;
    auto_release = 1'b1;
    send_frame(MAXF + 1, 8'h03, 0);
    idle(IDLE + 4);
    chk("t5_nodesc", desc_log.size(), 0);
    chk("t5_drop", drop_cnt, 1);
    send_byte(8'h77, 1'b0);
    chk("t5_next_addr", {ram_wren, ram_addr}, {1'b1, 12'd0});
    idle(IDLE + 4);
    expect_desc("t5_next", 12'd0, 12'd1);

    // Backpressure, then frm_rdy coinciding with a close.
    do_reset();
    frm_rdy = 1'b0;
    auto_release = 1'b1;
    send_byte(8'h5A, 1'b0);
    idle(IDLE + 3);
    chk("t6_a", {frm_vld, frm_addr, frm_len}, {1'b1, 12'd0, 12'd1});
    send_byte(8'h6B, 1'b0);
    idle(IDLE + 3);
    chk("t6_b_drop", drop_cnt, 1);
    chk("t6_a_held", {frm_vld, frm_addr, frm_len}, {1'b1, 12'd0, 12'd1});
    frm_rdy = 1'b1;
    @(negedge sysclk);
    chk("t6_vld_fall", frm_vld, 0);
    frm_rdy = 1'b0;
    idle(1);
    expect_desc("t6_a_acc", 12'd0, 12'd1);
    send_byte(8'h7C, 1'b0);
    chk("t6_rewound", {ram_wren, ram_addr}, {1'b1, 12'd1});
    idle(IDLE + 3);
    chk("t6_c", {frm_vld, frm_addr, frm_len}, {1'b1, 12'd1, 12'd1});
    send_byte(8'h8D, 1'b0);
    idle(IDLE - 1);
    frm_rdy = 1'b1;
    @(negedge sysclk);
    chk("t6_d_load", {frm_vld, frm_addr, frm_len}, {1'b1, 12'd2, 12'd1});
    chk("t6_d_drop", drop_cnt, 1);
    @(negedge sysclk);
    chk("t6_d_acc", frm_vld, 0);
    desc_log.delete();

    // Reset in the middle of a frame.
    do_reset();
    frm_rdy = 1'b1;
    auto_release = 1'b1;
    send_frame(2, 8'h10, 0);
    idle(IDLE + 4);
    expect_desc("t7_pre", 12'd0, 12'd2);
    send_frame(1, 8'h20, 1);
    idle(IDLE + 4);
    frm_rdy = 1'b0;
    send_frame(1, 8'h30, 0);
    idle(IDLE + 4);
    chk("t7_pre_state", {frm_vld, frm_addr, drop_cnt}, {1'b1, 12'd2, 16'd1});
    send_frame(3, 8'hA1, 0);
    chk("t7_pre_wr", {ram_wren, ram_addr, ram_data}, {1'b1, 12'd5, 8'hA3});
    #3;
    nRST = 1'b0;
    #1;
    chk("t7_rst_ram", {ram_wren, ram_addr, ram_data}, 0);
    chk("t7_rst_frm", {frm_vld, frm_addr, frm_len}, 0);
    chk("t7_rst_drop", drop_cnt, 0);
    chk("t7_rst_state", dbg_state, 0);
    rd_ptr = 12'd0;
    rel_pend = 1'b0;
    repeat (2) @(negedge sysclk);
    nRST = 1'b1;
    frm_rdy = 1'b1;
    wr_log.delete();
    desc_log.delete();
    send_byte(8'h44, 1'b0);
    chk("t7_post_addr", {ram_wren, ram_addr}, {1'b1, 12'd0});
    idle(IDLE + 4);
    expect_desc("t7_post", 12'd0, 12'd1);
    chk("t7_post_drop", drop_cnt, 0);

    // Random frames against a frame-level model of commit address and drop count.
    do_reset();
    frm_rdy = 1'b1;
    auto_release = 1'b1;
    m_commit = 12'd0;
    m_drop = 16'd0;
    for (int f = 0; f < 30; f++) begin
      len = $urandom_range(1, 24);
      errp = ($urandom_range(0, 3) == 0) ? $urandom_range(1, len) : 0;
      fb.delete();
      for (int i = 0; i < len; i++) begin
        d = 8'($urandom);
        fb.push_back(d);
        send_byte(d, errp == (i + 1));
        if (i < len - 1) begin
          r = $urandom_range(0, 5);
          g = (r == 0) ? IDLE - 1 : (r == 1) ? $urandom_range(1, IDLE - 2) : 0;
          idle(g);
        end
      end
      idle(IDLE + 4);
      if (errp == 0) begin
        exp_q.push_back({m_commit, 12'(len)});
        bad = 0;
        for (int i = 0; i < len; i++) begin
          a = m_commit + 12'(i);
          if (mem[a] !== fb[i]) bad++;
        end
        chk($sformatf("rnd%0d_bytes", f), bad, 0);
        m_commit = m_commit + 12'(len);
      end else begin
        m_drop = m_drop + 16'd1;
      end
      chk($sformatf("rnd%0d_desc_cnt", f), desc_log.size(), exp_q.size());
      while (desc_log.size() > 0 && exp_q.size() > 0) begin
        got = desc_log.pop_front();
        want = exp_q.pop_front();
        chk($sformatf("rnd%0d_desc", f), got, want);
      end
      desc_log.delete();
      exp_q.delete();
      chk($sformatf("rnd%0d_drop", f), drop_cnt, m_drop);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
